// File: rtl/dmem_arbiter.sv
// Round-robin req/gnt/ack arbiter sharing one sync-write/async-read data memory.
// Optional address range check: define DMEM_ARB_ADDR_CHECK_EN.
module dmem_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic          last;
  logic          sel;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          win;
  logic          bad;

  // On a tie the requester not served last wins
  assign win = m1_req & (~m0_req | ~last);

`ifdef DMEM_ARB_ADDR_CHECK_EN
  assign bad = (addr_r >= AW'(DEPTH));
`else
  // Constant 0; keeps DEPTH referenced in the unchecked build
  assign bad = 1'b0 && (DEPTH > 0);
`endif

  assign mem_a  = addr_r;
  assign mem_wd = wdata_r;
  assign mem_we = (state == ACCESS) & we_r & ~bad & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      sel      <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      m0_gnt   <= 1'b0;
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_gnt   <= 1'b0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (m0_req | m1_req) begin
            sel     <= win;
            we_r    <= win ? m1_we    : m0_we;
            addr_r  <= win ? m1_addr  : m0_addr;
            wdata_r <= win ? m1_wdata : m0_wdata;
            m0_gnt  <= ~win;
            m1_gnt  <= win;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
          if (sel) begin
            m1_ack <= 1'b1;
            m1_err <= bad;
            if (bad)
              m1_rdata <= '0;
            else if (!we_r)
              m1_rdata <= mem_rd;
          end else begin
            m0_ack <= 1'b1;
            m0_err <= bad;
            if (bad)
              m0_rdata <= '0;
            else if (!we_r)
              m0_rdata <= mem_rd;
          end
          state <= RESP;
        end
        RESP: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          m0_err <= 1'b0;
          m1_err <= 1'b0;
          last   <= sel;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter with a small behavioural memory.
// Define DMEM_ARB_ADDR_CHECK_EN to exercise the address range check.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [64];

  int applied = 0;
  int bad_cnt = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h100 + i;
  end
  always @(posedge clk) if (mem_we) mem[mem_a[5:0]] <= mem_wd;
  assign mem_rd = mem[mem_a[5:0]];

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [4:0]  ex;   // mem_we, gnt0, ack0, gnt1, ack1
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic rs, input logic r0, input logic w0,
    input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1,
    input logic [31:0] a1, input logic [31:0] d1,
    input logic [4:0] ex,
    input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t t;
    t.rst = rs; t.r0 = r0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
    t.r1 = r1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
    t.ex = ex; t.rd0 = rd0; t.rd1 = rd1;
    return t;
  endfunction

  task automatic check(input string name,
                       input logic [4:0] ex,
                       input logic [31:0] rd0,
                       input logic [31:0] rd1);
    logic [4:0] got;
    got = {mem_we, m0_gnt, m0_ack, m1_gnt, m1_ack};
    applied++;
    if (got !== ex || m0_rdata !== rd0 || m1_rdata !== rd1
        || m0_err !== 1'b0 || m1_err !== 1'b0) begin
      bad_cnt++;
      $display("FAIL %s: we/g0/k0/g1/k1=%b rd0=%h rd1=%h err=%b%b, want %b %h %h err=00",
               name, got, m0_rdata, m1_rdata, m0_err, m1_err, ex, rd0, rd1);
    end
  endtask

  task automatic expect1(input string name, input logic [31:0] got,
                         input logic [31:0] want);
    applied++;
    if (got !== want) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle_in();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  initial begin
    logic [31:0] x;
    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;

    // rst, m0 req/we/addr/wdata, m1 req/we/addr/wdata, expect, rd0, rd1
    tbl.push_back(v(1, 0,0, 0,0,  0,0, 0,0,  5'b00000, 0, 0));
    tbl.push_back(v(0, 1,1,40,2,  0,0, 0,0,  5'b11000, 0, 0));
    tbl.push_back(v(0, 0,0, 0,0,  0,0, 0,0,  5'b00100, 0, 0));
    tbl.push_back(v(0, 0,0, 0,0,  0,0, 0,0,  5'b00000, 0, 0));
    tbl.push_back(v(0, 1,0,40,0,  0,0, 0,0,  5'b01000, 0, 0));
    tbl.push_back(v(0, 0,0, 0,0,  0,0, 0,0,  5'b00100, 2, 0));
    tbl.push_back(v(0, 0,0, 0,0,  0,0, 0,0,  5'b00000, 2, 0));
    tbl.push_back(v(1, 0,0, 0,0,  0,0, 0,0,  5'b00000, 0, 0));
    // continuous contention after reset: m0, m1, m0, m1
    tbl.push_back(v(0, 1,0, 4,0,  1,0, 8,0,  5'b01000, 0, 0));
    tbl.push_back(v(0, 1,0, 4,0,  1,0, 8,0,  5'b00100, 32'h104, 0));
    tbl.push_back(v(0, 1,0, 4,0,  1,0, 8,0,  5'b00000, 32'h104, 0));
    tbl.push_back(v(0, 1,0, 4,0,  1,0, 8,0,  5'b00010, 32'h104, 0));
    tbl.push_back(v(0, 1,0, 4,0,  1,0, 8,0,  5'b00001, 32'h104, 32'h108));
    tbl.push_back(v(0, 1,0, 4,0,  1,0, 8,0,  5'b00000, 32'h104, 32'h108));
    tbl.push_back(v(0, 1,0, 4,0,  1,0, 8,0,  5'b01000, 32'h104, 32'h108));
    tbl.push_back(v(0, 1,0, 4,0,  1,0, 8,0,  5'b00100, 32'h104, 32'h108));
    tbl.push_back(v(0, 1,0, 4,0,  1,0, 8,0,  5'b00000, 32'h104, 32'h108));
    tbl.push_back(v(0, 1,0, 4,0,  1,0, 8,0,  5'b00010, 32'h104, 32'h108));
    tbl.push_back(v(0, 1,0, 4,0,  1,0, 8,0,  5'b00001, 32'h104, 32'h108));
    // lone m1 right after m1 was served
    tbl.push_back(v(0, 0,0, 0,0,  1,0, 8,0,  5'b00000, 32'h104, 32'h108));
    tbl.push_back(v(0, 0,0, 0,0,  1,0, 8,0,  5'b00010, 32'h104, 32'h108));
    tbl.push_back(v(0, 0,0, 0,0,  0,0, 0,0,  5'b00001, 32'h104, 32'h108));
    tbl.push_back(v(0, 0,0, 0,0,  0,0, 0,0,  5'b00000, 32'h104, 32'h108));
    // m1 write leaves m0 untouched, then read back
    tbl.push_back(v(0, 0,0, 0,0,  1,1, 3,32'h55, 5'b10010, 32'h104, 32'h108));
    tbl.push_back(v(0, 0,0, 0,0,  0,0, 0,0,  5'b00001, 32'h104, 32'h108));
    tbl.push_back(v(0, 0,0, 0,0,  0,0, 0,0,  5'b00000, 32'h104, 32'h108));
    tbl.push_back(v(0, 0,0, 0,0,  1,0, 3,0,  5'b00010, 32'h104, 32'h108));
    tbl.push_back(v(0, 0,0, 0,0,  0,0, 0,0,  5'b00001, 32'h104, 32'h55));
    tbl.push_back(v(0, 0,0, 0,0,  0,0, 0,0,  5'b00000, 32'h104, 32'h55));

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      m0_req = tbl[i].r0; m0_we = tbl[i].w0;
      m0_addr = tbl[i].a0; m0_wdata = tbl[i].d0;
      m1_req = tbl[i].r1; m1_we = tbl[i].w1;
      m1_addr = tbl[i].a1; m1_wdata = tbl[i].d1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].ex, tbl[i].rd0, tbl[i].rd1);
      if (i == 1) expect1("vec1_mem_a", mem_a, 32'd40);
    end
    rst = 1'b0;
    idle_in();

    // reset lands on the ACCESS cycle of an m0 write
    m0_req = 1; m0_we = 1; m0_addr = 12; m0_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("rstmid_gnt", 5'b11000, 32'h104, 32'h55);
    idle_in();
    rst = 1'b1;
    #1;
    expect1("rstmid_mem_we", {31'b0, mem_we}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_zero", 5'b00000, 0, 0);
    x = mem[12];
    expect1("rstmid_mem12", x, 32'h10C);
    @(posedge clk); #1;
    check("rstmid_noack", 5'b00000, 0, 0);

    // out-of-range write
    m0_req = 1; m0_we = 1; m0_addr = 1024; m0_wdata = 32'h77;
    @(posedge clk); #1;
    idle_in();
`ifdef DMEM_ARB_ADDR_CHECK_EN
    check("range_gnt", 5'b01000, 0, 0);
`else
    check("range_gnt", 5'b11000, 0, 0);
`endif
    @(posedge clk); #1;
    expect1("range_ack", {31'b0, m0_ack}, 1);
`ifdef DMEM_ARB_ADDR_CHECK_EN
    expect1("range_err", {31'b0, m0_err}, 1);
`else
    expect1("range_err", {31'b0, m0_err}, 0);
`endif
    expect1("range_rdata", m0_rdata, 0);
    @(posedge clk); #1;
    check("range_done", 5'b00000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, bad_cnt);
    $finish;
  end

endmodule
